leaf_uplink_arbiter: RTL and testbench

//   Merges NUM_LEAVES 64-bit valid/ready leaf streams onto one parent uplink.

---
 rtl/leaf_uplink_arbiter.sv | 100 ++++++++++
 tb/tb_leaf_uplink_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/leaf_uplink_arbiter.sv
// leaf_uplink_arbiter: round-robin merge of NUM_LEAVES valid/ready streams onto one registered uplink.
// Optional burst lock (MAX_BURST consecutive grants per leaf) is enabled by defining ARB_BURST_LOCK_EN.
module leaf_uplink_arbiter #(
    parameter int NUM_LEAVES = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4,
    parameter int SRC_WIDTH  = $clog2(NUM_LEAVES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [NUM_LEAVES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_LEAVES-1:0]            in_valid,
    output logic [NUM_LEAVES-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SRC_WIDTH-1:0]             out_src,
    output logic [31:0]                      word_count
);
    generate
        if (NUM_LEAVES < 2 || MAX_BURST < 1) begin : g_bad_cfg
            $error("leaf_uplink_arbiter: NUM_LEAVES must be >= 2 and MAX_BURST >= 1");
        end
    endgenerate

    logic [SRC_WIDTH-1:0] rr_ptr;
    logic [SRC_WIDTH-1:0] grant;
    logic [SRC_WIDTH-1:0] next_ptr;
    logic                 found;
    logic                 load_ok;
    logic                 xfer;

    // Scan from the highest offset down so the nearest valid leaf after rr_ptr wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = NUM_LEAVES - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_LEAVES) idx = idx - NUM_LEAVES;
            if (in_valid[idx]) begin
                grant = SRC_WIDTH'(idx);
                found = 1'b1;
            end
        end
    end

    assign load_ok  = reset && enable && (!out_valid || out_ready);
    assign xfer     = load_ok && found;
    assign in_ready = xfer ? ({{(NUM_LEAVES-1){1'b0}}, 1'b1} << grant) : '0;
    assign next_ptr = (grant == SRC_WIDTH'(NUM_LEAVES - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data   <= '0;
            out_src    <= '0;
            out_valid  <= 1'b0;
            word_count <= '0;
        end else if (xfer) begin
            out_data   <= in_data[grant*DATA_WIDTH +: DATA_WIDTH];
            out_src    <= grant;
            out_valid  <= 1'b1;
            word_count <= (word_count == 32'hFFFF_FFFF) ? word_count : word_count + 32'd1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ARB_BURST_LOCK_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_base;

    // A grant away from rr_ptr starts a fresh burst for the new leaf.
    assign burst_base = (grant == rr_ptr) ? burst_cnt : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (xfer) begin
            if (int'(burst_base) + 1 < MAX_BURST) begin
                rr_ptr    <= grant;
                burst_cnt <= burst_base + 1'b1;
            end else begin
                rr_ptr    <= next_ptr;
                burst_cnt <= '0;
            end
        end else if (load_ok && !in_valid[rr_ptr]) begin
            burst_cnt <= '0;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr <= '0;
        else if (xfer) rr_ptr <= next_ptr;
    end
`endif
endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// tb_leaf_uplink_arbiter: directed self-checking bench for the default (no burst lock) build.
module tb_leaf_uplink_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [255:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_src;
    logic [31:0]  word_count;
    int           n_cmp = 0;
    int           n_err = 0;

    leaf_uplink_arbiter dut (
        .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lw(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i);
    endfunction

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = lw(i);
        // reset held with all leaves requesting
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_src", 64'(out_src), 64'h0);
        chk("rst_word_count", 64'(word_count), 64'h0);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'h1);
        // round robin, one word per cycle
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("rr_src_%0d", k), 64'(out_src), 64'((k - 1) % 4));
            chk($sformatf("rr_valid_%0d", k), 64'(out_valid), 64'h1);
            chk($sformatf("rr_data_%0d", k), out_data, lw((k - 1) % 4));
        end
        chk("rr_word_count", 64'(word_count), 64'd8);
        // back-pressure with a leaf-2 word held
        in_data[2*64 +: 64] = 64'hDEAD_BEEF;
        in_valid = 4'b0100;
        tick();
        chk("hold_load_src", 64'(out_src), 64'h2);
        chk("hold_load_data", out_data, 64'hDEAD_BEEF);
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall_in_ready_%0d", k), 64'(in_ready), 64'h0);
            tick();
            chk($sformatf("stall_data_%0d", k), out_data, 64'hDEAD_BEEF);
            chk($sformatf("stall_src_%0d", k), 64'(out_src), 64'h2);
            chk($sformatf("stall_valid_%0d", k), 64'(out_valid), 64'h1);
        end
        chk("stall_word_count", 64'(word_count), 64'd9);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'h1);
        tick();
        chk("release_src", 64'(out_src), 64'h0);
        chk("release_data", out_data, lw(0));
        chk("release_word_count", 64'(word_count), 64'd10);
        // only leaf 3 requesting, then leaf 0 joins
        in_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("solo3_src_%0d", k), 64'(out_src), 64'h3);
        end
        in_valid = 4'b1001;
        tick();
        chk("wrap_src_a", 64'(out_src), 64'h0);
        tick();
        chk("wrap_src_b", 64'(out_src), 64'h3);
        tick();
        chk("wrap_src_c", 64'(out_src), 64'h0);
        chk("wrap_word_count", 64'(word_count), 64'd16);
        // disable while a word is pending
        enable    = 1'b0;
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #1;
        chk("dis_in_ready_a", 64'(in_ready), 64'h0);
        tick();
        chk("dis_held_valid", 64'(out_valid), 64'h1);
        chk("dis_held_src", 64'(out_src), 64'h0);
        out_ready = 1'b1;
        tick();
        chk("dis_drained_valid", 64'(out_valid), 64'h0);
        chk("dis_in_ready_b", 64'(in_ready), 64'h0);
        tick();
        chk("dis_idle_valid", 64'(out_valid), 64'h0);
        chk("dis_word_count", 64'(word_count), 64'd16);
        enable = 1'b1;
        #1;
        chk("en_in_ready", 64'(in_ready), 64'h2);
        tick();
        chk("en_src", 64'(out_src), 64'h1);
        chk("en_word_count", 64'(word_count), 64'd17);
        // no requests: register drains, count holds
        in_valid = 4'b0000;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'h0);
        tick();
        chk("idle_valid", 64'(out_valid), 64'h0);
        chk("idle_word_count", 64'(word_count), 64'd17);
        // async reset discards a held word
        in_valid = 4'b0100;
        #1;
        chk("pre_arst_in_ready", 64'(in_ready), 64'h4);
        tick();
        chk("pre_arst_data", out_data, 64'hDEAD_BEEF);
        chk("pre_arst_count", 64'(word_count), 64'd18);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_data", out_data, 64'h0);
        chk("arst_count", 64'(word_count), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
